// File: rtl/bfp_pkg.sv
// Shared types and helpers for the block-floating-point shift controller.
package bfp_pkg;

    // Entry fields are sized for the standard datapath configuration
    // (40-bit magnitude, 12-bit packet counter).
    localparam int unsigned DefIw   = 40;
    localparam int unsigned DefPktW = 12;
    localparam int unsigned DefSw   = $clog2(DefIw);

    typedef enum logic [0:0] {
        StIdle,
        StPkt
    } bfp_state_e;

    typedef struct packed {
        logic [DefSw-1:0]   shift;
        logic [DefPktW-1:0] len;
    } bfp_res_t;

    // Right shift that fits a magnitude plus sign bit into ow bits.
    // Zero magnitude needs no shift.
    function automatic logic [DefSw-1:0] calc_shift(input logic [DefIw-1:0] mag,
                                                     input int unsigned     iw,
                                                     input int unsigned     ow);
        int unsigned need;
        need = 0;
        for (int unsigned i = 0; i < DefIw; i++) begin
            if ((i < iw) && mag[i]) begin
                need = i + 2;
            end
        end
        if (need > ow) begin
            return DefSw'(need - ow);
        end
        return '0;
    endfunction

endpackage

// File: rtl/bfp_res_fifo.sv
// Result FIFO: DEPTH-entry synchronous queue of {shift, len} with
// simultaneous push/pop. A push into a full FIFO that is not popping is dropped.
module bfp_res_fifo
    import bfp_pkg::*;
#(
    parameter int unsigned DEPTH = 4  // power of two, at least 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  bfp_res_t push_data,
    input  logic     pop,
    output bfp_res_t head,
    output logic     empty,
    output logic     drop,
    output logic     nonempty_next
);

    localparam int unsigned AW = $clog2(DEPTH);

    bfp_res_t      mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    // Occupancy flags, accepted push/pop and next count.
    always_comb begin
        full    = (cnt_q == (AW+1)'(DEPTH));
        empty   = (cnt_q == '0);
        pop_ok  = pop & ~empty;
        // A pop frees the slot the push needs, so full+pop+push is legal.
        push_ok = push & (~full | pop_ok);
        drop    = push & full & ~pop_ok;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        nonempty_next = (cnt_d != '0);
        head          = mem_q[rptr_q];
    end

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bfp_shift_ctrl.sv
// Block-floating-point shift controller: tracks packet framing, captures the
// search_max result MAX_LAT cycles after each eop, converts it to a right-shift
// count and queues {shift, len} for the downstream scaler.
module bfp_shift_ctrl
    import bfp_pkg::*;
#(
    parameter int unsigned IW      = 40,
    parameter int unsigned OW      = 16,
    parameter int unsigned MAX_LAT = 3,
    parameter int unsigned PKT_W   = 12,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_sop,
    input  logic                  i_eop,
    input  logic                  i_vld,
    input  logic [IW-1:0]         i_max,
    input  logic                  i_clr_err,
    output logic                  o_shift_vld,
    input  logic                  i_shift_rdy,
    output logic [$clog2(IW)-1:0] o_shift,
    output logic [PKT_W-1:0]      o_pkt_len,
    output logic                  o_err_frm,
    output logic                  o_err_ovf,
    output logic                  o_busy
);

    localparam int unsigned SW = $clog2(IW);

    bfp_state_e         state_q;
    bfp_state_e         state_d;
    logic [PKT_W-1:0]   len_q;
    logic [PKT_W-1:0]   len_d;
    logic [PKT_W-1:0]   len_inc;
    logic               cap;
    logic [PKT_W-1:0]   cap_len;
    logic               frm_evt;

    logic [MAX_LAT-1:0] pipe_vld_q;
    logic [MAX_LAT-1:0] pipe_vld_d;
    logic [PKT_W-1:0]   pipe_len_q [MAX_LAT];
    logic               tag;

    bfp_res_t           res;
    bfp_res_t           fifo_head;
    logic               fifo_empty;
    logic               fifo_drop;
    logic               fifo_nonempty_next;

    logic               err_frm_q;
    logic               err_frm_d;
    logic               err_ovf_q;
    logic               err_ovf_d;
    logic               busy_q;
    logic               busy_d;

    // Framing FSM next state: packet length tracking and capture issue.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cap     = 1'b0;
        cap_len = '0;
        frm_evt = 1'b0;
        len_inc = (&len_q) ? len_q : len_q + PKT_W'(1);
        if (i_vld) begin
            case (state_q)
                StIdle: begin
                    if (i_sop && i_eop) begin
                        cap     = 1'b1;
                        cap_len = PKT_W'(1);
                    end else if (i_sop) begin
                        state_d = StPkt;
                        len_d   = PKT_W'(1);
                    end else if (i_eop) begin
                        frm_evt = 1'b1;
                    end
                end
                StPkt: begin
                    if (i_sop) begin
                        // Unexpected sop: abandon the open packet, restart on this beat.
                        frm_evt = 1'b1;
                        if (i_eop) begin
                            cap     = 1'b1;
                            cap_len = PKT_W'(1);
                            state_d = StIdle;
                        end else begin
                            len_d = PKT_W'(1);
                        end
                    end else if (i_eop) begin
                        cap     = 1'b1;
                        cap_len = len_inc;
                        state_d = StIdle;
                    end else begin
                        len_d = len_inc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Framing FSM state and length registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    // Capture pipe advance; the output stage lines up with search_max's result.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = cap;
        for (int unsigned k = 1; k < MAX_LAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
        end
    end

    // Capture pipe registers: tag and packet length per stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int unsigned k = 0; k < MAX_LAT; k++) begin
                pipe_len_q[k] <= '0;
            end
        end else begin
            pipe_vld_q    <= pipe_vld_d;
            pipe_len_q[0] <= cap_len;
            for (int unsigned k = 1; k < MAX_LAT; k++) begin
                pipe_len_q[k] <= pipe_len_q[k-1];
            end
        end
    end

    // Shift computation on i_max, valid only when the pipe output is tagged.
    always_comb begin
        tag       = pipe_vld_q[MAX_LAT-1];
        res.shift = calc_shift(DefIw'(i_max), IW, OW);
        res.len   = DefPktW'(pipe_len_q[MAX_LAT-1]);
    end

    bfp_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (tag),
        .push_data     (res),
        .pop           (i_shift_rdy),
        .head          (fifo_head),
        .empty         (fifo_empty),
        .drop          (fifo_drop),
        .nonempty_next (fifo_nonempty_next)
    );

    // Sticky error flags (a new error beats a same-cycle clear) and busy.
    always_comb begin
        err_frm_d = frm_evt | (err_frm_q & ~i_clr_err);
        err_ovf_d = fifo_drop | (err_ovf_q & ~i_clr_err);
        busy_d    = (state_d == StPkt) | (|pipe_vld_d) | fifo_nonempty_next;
    end

    // Flag and busy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_frm_q <= 1'b0;
            err_ovf_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            err_frm_q <= err_frm_d;
            err_ovf_q <= err_ovf_d;
            busy_q    <= busy_d;
        end
    end

    // Outputs straight from FIFO storage and flag registers.
    always_comb begin
        o_shift_vld = ~fifo_empty;
        o_shift     = fifo_head.shift[SW-1:0];
        o_pkt_len   = fifo_head.len[PKT_W-1:0];
        o_err_frm   = err_frm_q;
        o_err_ovf   = err_ovf_q;
        o_busy      = busy_q;
    end

endmodule

// File: tb/tb_bfp_shift_ctrl.sv
// Self-checking bench for bfp_shift_ctrl with a packet-level reference model.
module tb_bfp_shift_ctrl;

    localparam int IW    = 40;
    localparam int OW    = 16;
    localparam int LAT   = 3;
    localparam int PKT_W = 12;
    localparam int DEPTH = 4;
    localparam int LMAX  = (1 << PKT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_sop, i_eop, i_vld, i_clr_err, i_shift_rdy;
    logic [IW-1:0]     i_max;
    logic              o_shift_vld, o_err_frm, o_err_ovf, o_busy;
    logic [5:0]        o_shift;
    logic [PKT_W-1:0]  o_pkt_len;

    always #5 clk = ~clk;

    bfp_shift_ctrl #(
        .IW      (IW),
        .OW      (OW),
        .MAX_LAT (LAT),
        .PKT_W   (PKT_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sop       (i_sop),
        .i_eop       (i_eop),
        .i_vld       (i_vld),
        .i_max       (i_max),
        .i_clr_err   (i_clr_err),
        .o_shift_vld (o_shift_vld),
        .i_shift_rdy (i_shift_rdy),
        .o_shift     (o_shift),
        .o_pkt_len   (o_pkt_len),
        .o_err_frm   (o_err_frm),
        .o_err_ovf   (o_err_ovf),
        .o_busy      (o_busy)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int shift;
        int len;
    } ent_t;

    // Reference model: open packet, pending captures keyed by due cycle, result queue.
    ent_t            m_q[$];
    bit              m_open;
    int              m_len;
    bit              m_frm, m_ovf;
    bit              p_vld[8];
    longint unsigned p_max[8];
    int              p_len[8];
    int              cyc = 0;

    function automatic int exp_shift(input longint unsigned v);
        int need;
        if (v == 0) return 0;
        need = ($clog2(v + 1) - 1) + 2;
        return (need > OW) ? need - OW : 0;
    endfunction

    function automatic bit m_busy();
        bit b;
        b = m_open || (m_q.size() != 0);
        for (int i = 0; i < 8; i++) b = b || p_vld[i];
        return b;
    endfunction

    function automatic longint unsigned rnd_mag();
        longint unsigned r;
        r = {$urandom(), $urandom()};
        r = r >> $urandom_range(63, 24);
        return r & 64'hFF_FFFF_FFFF;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_open = 0;
        m_len  = 0;
        m_frm  = 0;
        m_ovf  = 0;
        for (int i = 0; i < 8; i++) p_vld[i] = 0;
    endtask

    // One clock: drive the beat, advance the model, return 1 time unit after the edge.
    task automatic tick(input bit sop, input bit eop, input bit vld, input bit rdy,
                        input bit clr, input longint unsigned mx);
        bit   cap, ferr, pop, push, drop;
        int   clen, n, slot;
        ent_t e;
        cap  = 0;
        ferr = 0;
        clen = 0;
        i_sop = sop; i_eop = eop; i_vld = vld; i_shift_rdy = rdy; i_clr_err = clr;
        if (vld) begin
            if (sop && m_open) ferr = 1;
            if (!sop && !m_open) begin
                if (eop) ferr = 1;
            end else begin
                n = sop ? 1 : ((m_len + 1 > LMAX) ? LMAX : m_len + 1);
                if (eop) begin
                    cap    = 1;
                    clen   = n;
                    m_open = 0;
                end else begin
                    m_open = 1;
                    m_len  = n;
                end
            end
        end
        if (cap) begin
            slot        = (cyc + LAT) % 8;
            p_vld[slot] = 1;
            p_max[slot] = mx;
            p_len[slot] = clen;
        end
        slot = cyc % 8;
        push = p_vld[slot];
        if (push) i_max = IW'(p_max[slot]);
        else i_max = IW'({$urandom(), $urandom()});
        e.shift = exp_shift(p_max[slot]);
        e.len   = p_len[slot];
        pop  = (m_q.size() != 0) && rdy;
        drop = push && (m_q.size() == DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(e);
        p_vld[slot] = 0;
        m_frm = ferr ? 1'b1 : (clr ? 1'b0 : m_frm);
        m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input bit rdy);
        tick(0, 0, 0, rdy, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_sop = 0; i_eop = 0; i_vld = 0; i_clr_err = 0; i_shift_rdy = 0; i_max = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_shift_vld !== 1'b0) begin failures++; $display("FAIL rst_vld: got %b want 0", o_shift_vld); end
        checks++; if (o_shift !== '0) begin failures++; $display("FAIL rst_shift: got %0d want 0", o_shift); end
        checks++; if (o_pkt_len !== '0) begin failures++; $display("FAIL rst_len: got %0d want 0", o_pkt_len); end
        checks++; if (o_err_frm !== 1'b0) begin failures++; $display("FAIL rst_frm: got %b want 0", o_err_frm); end
        checks++; if (o_err_ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b want 0", o_err_ovf); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_long_packet();
        tick(1, 0, 1, 0, 0, 0);
        repeat (6) tick(0, 0, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0, 64'h1234);      // eop at cycle t
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL lp_busy: got %b want 1", o_busy); end
        repeat (2) idle(0);                  // now at t+3
        checks++; if (o_shift_vld !== 1'b0) begin failures++; $display("FAIL lp_vld_early: got %b want 0", o_shift_vld); end
        idle(0);                             // t+4
        checks++; if (o_shift_vld !== 1'b1) begin failures++; $display("FAIL lp_vld: got %b want 1", o_shift_vld); end
        checks++; if (o_shift !== 6'd0) begin failures++; $display("FAIL lp_shift: got %0d want 0", o_shift); end
        checks++; if (o_pkt_len !== 12'd8) begin failures++; $display("FAIL lp_len: got %0d want 8", o_pkt_len); end
        idle(1);
        checks++; if (o_shift_vld !== 1'b0) begin failures++; $display("FAIL lp_pop: got %b want 0", o_shift_vld); end
        idle(0);
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL lp_idle_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_single_beat();
        tick(1, 1, 1, 0, 0, 64'h1 << 39);
        tick(1, 1, 1, 0, 0, 0);
        repeat (2) idle(0);
        checks++; if (o_shift_vld !== 1'b1 || o_shift !== 6'd25 || o_pkt_len !== 12'd1) begin
            failures++; $display("FAIL sb_top: got vld=%b shift=%0d len=%0d want 1/25/1", o_shift_vld, o_shift, o_pkt_len);
        end
        idle(1);
        checks++; if (o_shift_vld !== 1'b1 || o_shift !== 6'd0 || o_pkt_len !== 12'd1) begin
            failures++; $display("FAIL sb_zero: got vld=%b shift=%0d len=%0d want 1/0/1", o_shift_vld, o_shift, o_pkt_len);
        end
        idle(1);
        checks++; if (o_shift_vld !== 1'b0) begin failures++; $display("FAIL sb_empty: got %b want 0", o_shift_vld); end
    endtask

    task automatic test_back_to_back();
        int exp_sh[4] = '{0, 1, 6, 16};
        tick(1, 1, 1, 1, 0, 64'h1 << 14);
        tick(1, 1, 1, 1, 0, (64'h1 << 15) | 64'd5);
        tick(1, 1, 1, 1, 0, (64'h1 << 20) | 64'd123);
        tick(1, 1, 1, 1, 0, (64'h1 << 30) | 64'd7);
        for (int i = 0; i < 4; i++) begin
            checks++; if (o_shift_vld !== 1'b1 || o_shift !== 6'(exp_sh[i]) || o_pkt_len !== 12'd1) begin
                failures++; $display("FAIL b2b_%0d: got vld=%b shift=%0d len=%0d want 1/%0d/1", i, o_shift_vld, o_shift, o_pkt_len, exp_sh[i]);
            end
            idle(1);
        end
        checks++; if (o_shift_vld !== 1'b0) begin failures++; $display("FAIL b2b_end: got %b want 0", o_shift_vld); end
    endtask

    task automatic test_overflow();
        longint unsigned vals[6];
        for (int i = 0; i < 6; i++) begin
            vals[i] = rnd_mag();
            tick(1, 1, 1, 0, 0, vals[i]);
        end
        idle(0);                             // fourth push visible
        checks++; if (o_err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", o_err_ovf); end
        idle(0);                             // fifth push dropped
        checks++; if (o_err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", o_err_ovf); end
        idle(0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (o_shift_vld !== 1'b1 || o_shift !== 6'(exp_shift(vals[i])) || o_pkt_len !== 12'd1) begin
                failures++; $display("FAIL ovf_drain_%0d: got vld=%b shift=%0d len=%0d want 1/%0d/1", i, o_shift_vld, o_shift, o_pkt_len, exp_shift(vals[i]));
            end
            idle(1);
        end
        checks++; if (o_shift_vld !== 1'b0) begin failures++; $display("FAIL ovf_empty: got %b want 0", o_shift_vld); end
        checks++; if (o_err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", o_err_ovf); end
        tick(0, 0, 0, 1, 1, 0);
        checks++; if (o_err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %b want 0", o_err_ovf); end
    endtask

    task automatic test_framing();
        longint unsigned v;
        v = rnd_mag();
        tick(1, 0, 1, 0, 0, 0);
        repeat (4) tick(0, 0, 1, 0, 0, 0);
        checks++; if (o_err_frm !== 1'b0) begin failures++; $display("FAIL frm_clean: got %b want 0", o_err_frm); end
        tick(1, 0, 1, 0, 0, 0);              // sop inside an open packet
        checks++; if (o_err_frm !== 1'b1) begin failures++; $display("FAIL frm_set: got %b want 1", o_err_frm); end
        repeat (2) tick(0, 0, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0, v);
        repeat (3) idle(0);
        checks++; if (o_shift_vld !== 1'b1 || o_pkt_len !== 12'd4 || o_shift !== 6'(exp_shift(v))) begin
            failures++; $display("FAIL frm_res: got vld=%b shift=%0d len=%0d want 1/%0d/4", o_shift_vld, o_shift, o_pkt_len, exp_shift(v));
        end
        repeat (3) idle(1);
        checks++; if (o_shift_vld !== 1'b0) begin failures++; $display("FAIL frm_one: got %b want 0", o_shift_vld); end
        tick(0, 1, 1, 1, 0, 0);              // eop with no packet open
        repeat (5) idle(1);
        checks++; if (o_shift_vld !== 1'b0) begin failures++; $display("FAIL frm_idle_eop: got %b want 0", o_shift_vld); end
        checks++; if (o_err_frm !== 1'b1) begin failures++; $display("FAIL frm_stay: got %b want 1", o_err_frm); end
        tick(0, 1, 1, 1, 1, 0);              // clear with a new error in the same cycle
        checks++; if (o_err_frm !== 1'b1) begin failures++; $display("FAIL frm_clr_race: got %b want 1", o_err_frm); end
        tick(0, 0, 0, 1, 1, 0);
        checks++; if (o_err_frm !== 1'b0) begin failures++; $display("FAIL frm_clr: got %b want 0", o_err_frm); end
    endtask

    task automatic test_saturation();
        tick(1, 0, 1, 0, 0, 0);
        repeat (4200) tick(0, 0, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0, 64'h1);
        repeat (3) idle(0);
        checks++; if (o_pkt_len !== 12'(LMAX) || o_shift_vld !== 1'b1) begin
            failures++; $display("FAIL sat_len: got vld=%b len=%0d want 1/%0d", o_shift_vld, o_pkt_len, LMAX);
        end
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            checks++; if (o_shift_vld !== (m_q.size() != 0)) begin
                failures++; $display("FAIL rnd_vld@%0d: got %b want %b", cyc, o_shift_vld, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++; if (o_shift !== 6'(m_q[0].shift) || o_pkt_len !== 12'(m_q[0].len)) begin
                    failures++; $display("FAIL rnd_head@%0d: got shift=%0d len=%0d want %0d/%0d", cyc, o_shift, o_pkt_len, m_q[0].shift, m_q[0].len);
                end
            end
            checks++; if (o_err_frm !== m_frm || o_err_ovf !== m_ovf || o_busy !== m_busy()) begin
                failures++; $display("FAIL rnd_flags@%0d: got frm=%b ovf=%b busy=%b want %b/%b/%b", cyc, o_err_frm, o_err_ovf, o_busy, m_frm, m_ovf, m_busy());
            end
            tick(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 4) != 0,
                 ($urandom % 2) == 0, ($urandom % 16) == 0, rnd_mag());
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        tick(1, 1, 1, 0, 0, rnd_mag());
        tick(1, 1, 1, 0, 0, rnd_mag());
        idle(0);
        tick(1, 1, 1, 0, 0, rnd_mag());
        tick(1, 1, 1, 0, 0, rnd_mag());
        checks++; if (o_shift_vld !== 1'b1 || o_busy !== 1'b1) begin
            failures++; $display("FAIL mrst_pre: got vld=%b busy=%b want 1/1", o_shift_vld, o_busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({o_shift_vld, o_shift, o_pkt_len, o_err_frm, o_err_ovf, o_busy} !== '0) begin
            failures++; $display("FAIL mrst_out: got vld=%b shift=%0d len=%0d frm=%b ovf=%b busy=%b want all 0", o_shift_vld, o_shift, o_pkt_len, o_err_frm, o_err_ovf, o_busy);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            idle(1);
            checks++; if (o_shift_vld !== 1'b0 || o_busy !== 1'b0) begin
                failures++; $display("FAIL mrst_after_%0d: got vld=%b busy=%b want 0/0", i, o_shift_vld, o_busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_sop = 0; i_eop = 0; i_vld = 0; i_clr_err = 0; i_shift_rdy = 0; i_max = '0;
        model_reset();
        test_reset();
        test_long_packet();
        test_single_beat();
        test_back_to_back();
        test_overflow();
        test_framing();
        test_saturation();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bfp_shift_ctrl.md
# bfp_shift_ctrl

Block-floating-point shift controller for the PUSCH dimension-reduction datapath. It watches the same packet stream that feeds `search_max` and tracks packet framing. It captures the per-packet OR-magnitude result after the fixed `search_max` latency, converts it to a right-shift count that fits the packet into a signed OW-bit output, and queues {shift, packet length} in a small ready/valid FIFO for the downstream scaler.

## Interface
- `IW`, 40, input/`i_max` width; must match the `search_max` instance
- `OW`, 16, signed output width the scaler targets
- `MAX_LAT`, 3, cycles from an accepted `i_eop` beat to a valid `i_max`; fixed by `search_max`
- `PKT_W`, 12, packet-length counter width
- `DEPTH`, 4, result FIFO depth; power of two
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `i_sop`, `i_eop`, `i_vld`  in  1 each  stream framing; same signals that drive `search_max`
- `i_max`  in  IW  `o_max` of `search_max`
- `i_clr_err`  in  1  synchronous clear of the sticky error flags
- `o_shift_vld`  out  1  FIFO head valid
- `i_shift_rdy`  in  1  downstream accepts head
- `o_shift`  out  SW=$clog2(IW)  right-shift amount
- `o_pkt_len`  out  PKT_W  beat count of that packet
- `o_err_frm`  out  1  sticky framing error
- `o_err_ovf`  out  1  sticky FIFO overflow
- `o_busy`  out  1  packet open, capture pending, or FIFO non-empty

## Operation
- Framing FSM, states IDLE and PKT. Only beats with `i_vld=1` are examined.
  - IDLE, sop&!eop: go to PKT, len=1.
  - IDLE, sop&eop: single-beat packet; issue capture with len=1; stay in IDLE.
  - IDLE, eop&!sop: set `o_err_frm`; no capture.
  - PKT, plain beat: len+1, saturating at 2^PKT_W-1.
  - PKT, eop: issue capture with the final len (including the eop beat); go to IDLE.
  - PKT, sop: set `o_err_frm`; discard the open packet with no capture; restart len=1. With sop&eop on the same beat, it is a single-beat packet.
- Capture pipe: a MAX_LAT-stage shift register of {tag, len}. It is loaded on the eop beat. Back-to-back eops on consecutive cycles are supported with no loss.
- At the pipe output tag, `i_max` is sampled and the shift is computed:
  - msb = index of the highest set bit of `i_max`.
  - need = msb+2 (magnitude plus sign).
  - shift = need-OW if need>OW, else 0.
  - `i_max`=0 gives shift=0.
  - Example: IW=40, OW=16, `i_max`=2^(IW-1) gives shift=25.
- The result {shift, len} is pushed into the FIFO.
- FIFO rules:
  - Pop when `o_shift_vld & i_shift_rdy`.
  - Push while full and not popping: drop the new entry and set `o_err_ovf`.
  - Push and pop in the same cycle while full: both happen; no error.
- Error flags are sticky:
  - Cleared by `rst`.
  - Also cleared by `i_clr_err`, unless a new error occurs in that same cycle; a new error wins.
- Reset: FSM goes to IDLE; pipe, FIFO pointers and count, flags and all outputs go to 0. A packet in progress at reset is lost.

## Timing
- Eop beat at cycle t: the pipe output tag is at t+MAX_LAT. `i_max` is sampled and the push is registered that cycle. `o_shift_vld` rises at t+MAX_LAT+1 when the FIFO was empty.
- `o_shift` and `o_pkt_len` are driven from FIFO storage. They hold stable while `o_shift_vld=1` and `i_shift_rdy=0`.
- Throughput: one result per cycle sustained when `i_shift_rdy=1`.
- `o_err_*` assert in the cycle after the offending beat, or after the dropped push.
- `o_busy` is registered.

## Structure
- Package `bfp_pkg`:
  - function `calc_shift(max, IW, OW)` (priority encoder plus subtraction)
  - typedef for the FIFO entry struct {shift, len}
  - FSM state enum
- Sub-module `bfp_res_fifo`: DEPTH-entry synchronous FIFO with full/empty and simultaneous push/pop. The FSM, capture pipe and shift calculation stay in the top level.

## Test plan
- 8-beat packet; model `i_max`=0x0000_1234 at eop+3 -> shift=0 (msb=12, need 14), len=8, `o_shift_vld` at eop+4.
- Single beat sop&eop with `i_max`=2^(IW-1) -> shift=25, len=1. With `i_max`=0 -> shift=0.
- Four back-to-back single-beat packets with distinct `i_max` (msb 14, 15, 20, 30) and `i_shift_rdy`=1 -> shifts 0, 1, 6, 16 on consecutive cycles.
- `i_shift_rdy`=0 while six packets complete -> four entries held, `o_err_ovf`=1 after the fifth push. Then raise rdy -> the original four drain in order. `i_clr_err` clears the flag.
- sop mid-packet after 5 beats, then 3 more beats and eop -> `o_err_frm`=1, exactly one result with len=4. Eop in IDLE -> flag stays set, no result.
- Assert `rst` with two captures in the pipe and two FIFO entries -> all outputs 0 on the next edge; no results emerge after release.
